// File: rtl/mvma_row_sequencer_if.sv
// Handshake and datapath-control bundle between the row sequencer and its
// surroundings (upstream stream, x/weight/bias memories, accumulator, downstream).
interface mvma_row_sequencer_if #(
  parameter int XW = 3,
  parameter int WW = 6,
  parameter int BW = 3
);
  logic          s_valid;
  logic          s_ready;
  logic          m_valid;
  logic          m_ready;
  logic          wr_en_x;
  logic [XW-1:0] addr_x;
  logic [WW-1:0] addr_w;
  logic [BW-1:0] addr_b;
  logic          acc_first;
  logic          acc_vld;
  logic          acc_last;
  logic [BW-1:0] row_idx;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
           acc_first, acc_vld, acc_last, row_idx
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
           acc_first, acc_vld, acc_last, row_idx
  );
endinterface

// File: rtl/mvma_row_sequencer.sv
// Buffers one N-element vector, then walks M rows through the shared MAC
// datapath, with accumulator control delayed LAT cycles to meet the products.
module mvma_row_sequencer #(
  parameter int M   = 6,
  parameter int N   = 8,
  parameter int LAT = 2,
  parameter int XW  = $clog2(N),
  parameter int WW  = $clog2(M*N),
  parameter int BW  = $clog2(M)
) (
  input  logic clk,
  input  logic reset,
  mvma_row_sequencer_if.master bus
);
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, PRESENT} state_t;
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tok_t;

  state_t        state_q, state_d;
  logic [XW-1:0] in_cnt_q, in_cnt_d;
  logic [XW-1:0] k_q, k_d;
  logic [BW-1:0] row_q, row_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  tok_t          tok_in;
  tok_t          tok_pipe [LAT:1];
  logic          accept, fire;

  // Reset gating keeps the x write strobe quiet while reset is asserted.
  assign bus.s_ready = (state_q == LOAD);
  assign accept      = bus.s_valid & bus.s_ready & reset;
  assign fire        = bus.m_valid & bus.m_ready;
  assign bus.wr_en_x = accept;
  assign bus.m_valid = (state_q == PRESENT);

  // k stays at N-1 through DRAIN/PRESENT so addresses hold stable.
  assign bus.addr_x  = (state_q == LOAD) ? in_cnt_q : k_q;
  assign bus.addr_w  = WW'(row_q) * WW'(N) + WW'(k_q);
  assign bus.addr_b  = row_q;
  assign bus.row_idx = row_q;

  assign bus.acc_vld   = tok_pipe[LAT].vld;
  assign bus.acc_first = tok_pipe[LAT].first;
  assign bus.acc_last  = tok_pipe[LAT].last;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    k_d      = k_q;
    row_d    = row_q;
    dcnt_d   = dcnt_q;
    tok_in   = '0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (in_cnt_q == XW'(N-1)) begin
            in_cnt_d = '0;
            row_d    = '0;
            k_d      = '0;
            state_d  = ISSUE;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        tok_in = '{vld: 1'b1, first: (k_q == '0), last: (k_q == XW'(N-1))};
        if (k_q == XW'(N-1)) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(LAT-1)) state_d = PRESENT;
        else                      dcnt_d  = dcnt_q + 1'b1;
      end
      PRESENT: begin
        if (fire) begin
          k_d = '0;
          if (row_q == BW'(M-1)) begin
            row_d   = '0;
            state_d = LOAD;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      in_cnt_q <= '0;
      k_q      <= '0;
      row_q    <= '0;
      dcnt_q   <= '0;
      for (int i = 1; i <= LAT; i++) tok_pipe[i] <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      k_q      <= k_d;
      row_q    <= row_d;
      dcnt_q   <= dcnt_d;
      tok_pipe[1] <= tok_in;
      for (int i = 2; i <= LAT; i++) tok_pipe[i] <= tok_pipe[i-1];
    end
  end
endmodule

// File: tb/tb_mvma_row_sequencer.sv
// Directed bench for mvma_row_sequencer: vector table for load + row 0,
// hand-written sequences for later rows, backpressure, wrap and mid-run reset.
module tb_mvma_row_sequencer;
  localparam int M = 6, N = 8, LAT = 2;

  typedef struct {
    logic sv, mr;
    logic sr, mv, wr;
    int   ax, aw, ab;
    logic af, av, al;
    int   ri;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   fires = 0;
  vec_t tab [$];

  mvma_row_sequencer_if #(.XW(3), .WW(6), .BW(3)) bus ();

  mvma_row_sequencer #(.M(M), .N(N), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic sv, logic mr, logic sr, logic mv, logic wr,
                              int ax, int aw, int ab, logic af, logic av, logic al);
    vec_t v;
    v.sv = sv; v.mr = mr; v.sr = sr; v.mv = mv; v.wr = wr;
    v.ax = ax; v.aw = aw; v.ab = ab; v.af = af; v.av = av; v.al = al; v.ri = ab;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, vec_t e);
    chk({tag, ".s_ready"},   32'(bus.s_ready),   32'(e.sr));
    chk({tag, ".m_valid"},   32'(bus.m_valid),   32'(e.mv));
    chk({tag, ".wr_en_x"},   32'(bus.wr_en_x),   32'(e.wr));
    chk({tag, ".addr_x"},    32'(bus.addr_x),    e.ax);
    chk({tag, ".addr_w"},    32'(bus.addr_w),    e.aw);
    chk({tag, ".addr_b"},    32'(bus.addr_b),    e.ab);
    chk({tag, ".acc_first"}, 32'(bus.acc_first), 32'(e.af));
    chk({tag, ".acc_vld"},   32'(bus.acc_vld),   32'(e.av));
    chk({tag, ".acc_last"},  32'(bus.acc_last),  32'(e.al));
    chk({tag, ".row_idx"},   32'(bus.row_idx),   e.ri);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full row from its first ISSUE cycle; bp cycles of m_ready=0 in PRESENT.
  task automatic run_row(int r, int bp);
    for (int c = 0; c <= N + LAT + bp; c++) begin
      int k;
      k = (c < N) ? c : N - 1;
      bus.s_valid = 1'b1;
      bus.m_ready = (c < N + LAT) ? 1'b1 : (c == N + LAT + bp);
      #1;
      chk_out($sformatf("row%0d_c%0d", r, c),
              mk(1'b1, bus.m_ready, 1'b0, (c >= N + LAT), 1'b0, k, r*N + k, r,
                 (c == LAT), (c >= LAT && c <= N + LAT - 1), (c == N + LAT - 1)));
      if (bus.m_valid && bus.m_ready) fires++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Load with 3 gaps, then row 0 of the vector (t0 = entry 11).
    //            sv mr sr mv wr ax aw ab af av al
    tab.push_back(mk(1,0,1,0,1, 0,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 1,0,0, 0,0,0));
    tab.push_back(mk(0,0,1,0,0, 2,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 2,0,0, 0,0,0));
    tab.push_back(mk(0,0,1,0,0, 3,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 3,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 4,0,0, 0,0,0));
    tab.push_back(mk(0,0,1,0,0, 5,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 5,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 6,0,0, 0,0,0));
    tab.push_back(mk(1,0,1,0,1, 7,0,0, 0,0,0));
    tab.push_back(mk(1,1,0,0,0, 0,0,0, 0,0,0));
    tab.push_back(mk(1,1,0,0,0, 1,1,0, 0,0,0));
    tab.push_back(mk(1,1,0,0,0, 2,2,0, 1,1,0));
    tab.push_back(mk(1,1,0,0,0, 3,3,0, 0,1,0));
    tab.push_back(mk(1,1,0,0,0, 4,4,0, 0,1,0));
    tab.push_back(mk(1,1,0,0,0, 5,5,0, 0,1,0));
    tab.push_back(mk(1,1,0,0,0, 6,6,0, 0,1,0));
    tab.push_back(mk(1,1,0,0,0, 7,7,0, 0,1,0));
    tab.push_back(mk(1,1,0,0,0, 7,7,0, 0,1,0));
    tab.push_back(mk(1,1,0,0,0, 7,7,0, 0,1,1));
    tab.push_back(mk(1,1,0,1,0, 7,7,0, 0,0,0));

    reset = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #2;
    chk_out("reset0", mk(0,0,1,0,0, 0,0,0, 0,0,0));
    #1 reset = 1'b1;
    tick();

    foreach (tab[i]) begin
      bus.s_valid = tab[i].sv;
      bus.m_ready = tab[i].mr;
      #1;
      chk_out($sformatf("tab%0d", i), tab[i]);
      if (bus.m_valid && bus.m_ready) fires++;
      tick();
    end

    for (int r = 1; r < M; r++) run_row(r, (r == 3) ? 5 : 0);

    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk_out("wrap_load", mk(0,0,1,0,0, 0,0,0, 0,0,0));
    chk("fire_count", 32'(fires), 32'(M));

    // Second vector, contiguous load.
    for (int i = 0; i < N; i++) begin
      bus.s_valid = 1'b1;
      #1;
      chk_out($sformatf("v2_load%0d", i), mk(1,0,1,0,1, i,0,0, 0,0,0));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      bus.s_valid = 1'b1;
      #1;
      chk_out($sformatf("v2_issue%0d", k),
              mk(1,0,0,0,0, k,k,0, (k == LAT), (k >= LAT), 0));
      if (k < 3) tick();
    end

    // Asynchronous reset mid-ISSUE with tokens in flight, no clock edge.
    reset = 1'b0;
    #1;
    chk_out("mid_reset", mk(1,0,1,0,0, 0,0,0, 0,0,0));
    bus.s_valid = 1'b0;
    #2 reset = 1'b1;
    tick();
    bus.s_valid = 1'b1;
    #1;
    chk_out("post_rst0", mk(1,0,1,0,1, 0,0,0, 0,0,0));
    tick();
    #1;
    chk_out("post_rst1", mk(1,0,1,0,1, 1,0,0, 0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
